dmem_lsu: RTL and testbench

- Load/store unit: the initiator side of the data-memory port of the 2-read/1-write DPI RAM.
- Takes one load or store request at a time from the execute stage over a valid/ready handshake.
- Checks alignment and range, then drives the RAM's dmem_* port for exactly one cycle.
- Registers the lane-shifted and sign- or zero-extended load result, and returns it on a valid/ready response channel.

---
 rtl/dmem_lsu_pkg.sv | 53 +++++
 rtl/dmem_lsu_if.sv | 26 ++
 rtl/dmem_lsu_align.sv | 34 +++
 rtl/dmem_lsu.sv | 155 +++++++++++++++
 tb/tb_dmem_lsu.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [XLEN-1:0] DEF_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] DEF_MEM_BYTES = 64'h0000_0000_0800_0000;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FAULT    = 2'b10
  } err_e;

  // Request fields still needed once the RAM access is under way.
  typedef struct packed {
    logic [2:0] off;
    size_e      size;
    logic       sgn;
    logic       wen;
  } lsu_req_t;

  function automatic logic [XLEN-1:0] size_mask(input size_e sz);
    case (sz)
      SZ_B:    size_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    size_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input size_e sz);
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response channel between the execute stage and the load/store unit.
interface dmem_lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  size_e       req_size;
  logic        req_signed;
  logic        req_wen;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  err_e        resp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_size, req_signed, req_wen, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_size, req_signed, req_wen, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Byte-lane positioning for stores and shift/extend for loads (combinational).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  off_i,
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] wmask_c_o,
  output logic [63:0] wdata_c_o,
  output logic [63:0] rdata_c_o
);

  logic [5:0]  shamt;
  logic [63:0] rsh;

  assign shamt     = {off_i, 3'b000};
  assign wmask_c_o = size_mask(size_i) << shamt;
  assign wdata_c_o = wdata_i << shamt;
  assign rsh       = rdata_i >> shamt;

  // Double loads ignore the signed flag: there is nothing left to extend.
  always_comb begin
    rdata_c_o = rsh;
    case (size_i)
      SZ_B:    rdata_c_o = {{56{signed_i & rsh[7]}},  rsh[7:0]};
      SZ_H:    rdata_c_o = {{48{signed_i & rsh[15]}}, rsh[15:0]};
      SZ_W:    rdata_c_o = {{32{signed_i & rsh[31]}}, rsh[31:0]};
      default: rdata_c_o = rsh;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: checks a request, drives the RAM data port for one cycle,
// and returns the extended load data or an error on the response channel.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [63:0] MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_lsu_if.slave   req_if,
  output logic        dmem_en,
  output logic [63:0] dmem_addr,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] dmem_wdata,
  output logic [63:0] dmem_wmask,
  output logic        dmem_wen
);

  localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

  state_e      state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  err_e        resp_err_q, resp_err_d;
  logic        dmem_en_q, dmem_en_d;
  logic        dmem_wen_q, dmem_wen_d;
  logic [63:0] dmem_addr_q, dmem_addr_d;
  logic [63:0] dmem_wdata_q, dmem_wdata_d;
  logic [63:0] dmem_wmask_q, dmem_wmask_d;

  // One aligner serves both phases: incoming request in IDLE, latched request after.
  logic        in_idle;
  logic [2:0]  al_off;
  size_e       al_size;
  logic        al_sgn;
  logic [63:0] al_wmask, al_wdata, al_rdata;

  assign in_idle = (state_q == IDLE);
  assign al_off  = in_idle ? req_if.req_addr[2:0] : req_q.off;
  assign al_size = in_idle ? req_if.req_size      : req_q.size;
  assign al_sgn  = in_idle ? req_if.req_signed    : req_q.sgn;

  lsu_align u_align (
    .off_i     (al_off),
    .size_i    (al_size),
    .signed_i  (al_sgn),
    .wdata_i   (req_if.req_wdata),
    .rdata_i   (dmem_rdata),
    .wmask_c_o (al_wmask),
    .wdata_c_o (al_wdata),
    .rdata_c_o (al_rdata)
  );

  // 65-bit range check so addr+bytes cannot wrap past 2^64.
  logic [64:0] end_c;
  logic        misalign_c, fault_c;

  assign end_c      = {1'b0, req_if.req_addr} + (65'(1) << req_if.req_size);
  assign misalign_c = misaligned(req_if.req_addr[2:0], req_if.req_size);
  assign fault_c    = (req_if.req_addr < BASE_ADDR) || (end_c > LIMIT);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    dmem_en_d    = 1'b0;
    dmem_wen_d   = 1'b0;
    dmem_addr_d  = '0;
    dmem_wdata_d = '0;
    dmem_wmask_d = '0;

    case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          req_d = '{off: req_if.req_addr[2:0], size: req_if.req_size,
                    sgn: req_if.req_signed, wen: req_if.req_wen};
          if (misalign_c || fault_c) begin
            resp_err_d   = misalign_c ? ERR_MISALIGN : ERR_FAULT;
            resp_rdata_d = '0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            dmem_en_d   = 1'b1;
            dmem_wen_d  = req_if.req_wen;
            dmem_addr_d = req_if.req_addr;
            if (req_if.req_wen) begin
              dmem_wdata_d = al_wdata;
              dmem_wmask_d = al_wmask;
            end
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        resp_rdata_d = req_q.wen ? '0 : al_rdata;
        resp_err_d   = ERR_OK;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (req_if.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '{off: 3'd0, size: SZ_B, sgn: 1'b0, wen: 1'b0};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
      dmem_en_q    <= 1'b0;
      dmem_wen_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wmask_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      dmem_en_q    <= dmem_en_d;
      dmem_wen_q   <= dmem_wen_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wmask_q <= dmem_wmask_d;
    end
  end

  assign req_if.req_ready  = req_ready_q;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_rdata = resp_rdata_q;
  assign req_if.resp_err   = resp_err_q;
  assign dmem_en           = dmem_en_q;
  assign dmem_wen          = dmem_wen_q;
  assign dmem_addr         = dmem_addr_q;
  assign dmem_wdata        = dmem_wdata_q;
  assign dmem_wmask        = dmem_wmask_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small 16-word RAM model on the dmem port.
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_en, dmem_wen;
  logic [63:0] dmem_addr, dmem_rdata, dmem_wdata, dmem_wmask;
  logic [63:0] mem [16];
  int          checks = 0;
  int          failures = 0;
  int          en_cnt = 0;

  always #5 clk = ~clk;

  dmem_lsu_if bus ();

  dmem_lsu #(
    .BASE_ADDR (64'h0000_0000_8000_0000),
    .MEM_BYTES (64'h0000_0000_0800_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_if     (bus),
    .dmem_en    (dmem_en),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .dmem_wdata (dmem_wdata),
    .dmem_wmask (dmem_wmask),
    .dmem_wen   (dmem_wen)
  );

  assign dmem_rdata = mem[dmem_addr[6:3]];

  always @(posedge clk) begin
    if (dmem_en) en_cnt <= en_cnt + 1;
    if (dmem_en && dmem_wen)
      mem[dmem_addr[6:3]] <= (mem[dmem_addr[6:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, ":req_ready"},  64'(bus.req_ready),  64'd1);
    chk({tag, ":resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, ":resp_rdata"}, bus.resp_rdata,      64'd0);
    chk({tag, ":resp_err"},   64'(bus.resp_err),   64'd0);
    chk({tag, ":dmem_en"},    64'(dmem_en),        64'd0);
    chk({tag, ":dmem_wen"},   64'(dmem_wen),       64'd0);
    chk({tag, ":dmem_addr"},  dmem_addr,           64'd0);
    chk({tag, ":dmem_wdata"}, dmem_wdata,          64'd0);
    chk({tag, ":dmem_wmask"}, dmem_wmask,          64'd0);
  endtask

  task automatic drive(input logic [63:0] addr, input logic [63:0] wdata, input size_e sz,
                       input logic sgn, input logic wen);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_wen    = wen;
  endtask

  // One full transaction with resp_ready held high.
  task automatic access(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                        input size_e sz, input logic sgn, input logic wen, input err_e exp_err,
                        input logic [63:0] exp_rdata, input logic [63:0] exp_wmask,
                        input logic [63:0] exp_wdata);
    int en0;
    @(negedge clk);
    drive(addr, wdata, sz, sgn, wen);
    en0 = en_cnt;
    chk({tag, ":req_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (exp_err == ERR_OK) begin
      chk({tag, ":dmem_en"},    64'(dmem_en),        64'd1);
      chk({tag, ":dmem_wen"},   64'(dmem_wen),       64'(wen));
      chk({tag, ":dmem_addr"},  dmem_addr,           addr);
      chk({tag, ":dmem_wmask"}, dmem_wmask,          exp_wmask);
      chk({tag, ":dmem_wdata"}, dmem_wdata,          exp_wdata);
      chk({tag, ":early_vld"},  64'(bus.resp_valid), 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, ":resp_valid"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, ":resp_err"},   64'(bus.resp_err),   64'(exp_err));
    chk({tag, ":resp_rdata"}, bus.resp_rdata,      exp_rdata);
    chk({tag, ":en_in_resp"}, 64'(dmem_en),        64'd0);
    chk({tag, ":wmask_resp"}, dmem_wmask,          64'd0);
    chk({tag, ":ready_resp"}, 64'(bus.req_ready),  64'd0);
    chk({tag, ":en_cycles"},  64'(en_cnt - en0),   (exp_err == ERR_OK) ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    chk({tag, ":vld_drop"},   64'(bus.resp_valid), 64'd0);
    chk({tag, ":ready_back"}, 64'(bus.req_ready),  64'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
    mem[1]  <= 64'h0123_4567_89AB_CDEF;
    mem[15] <= 64'hCAFE_BABE_0000_0000;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = SZ_B;
    bus.req_signed = 1'b0;
    bus.req_wen    = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Double store then load back
    access("st_d", 64'h8000_0000, 64'h1122_3344_5566_7788, SZ_D, 1'b0, 1'b1, ERR_OK,
           64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788);
    chk("mem_after_st_d", mem[0], 64'h1122_3344_5566_7788);
    access("ld_d", 64'h8000_0000, 64'd0, SZ_D, 1'b0, 1'b0, ERR_OK,
           64'h1122_3344_5566_7788, 64'd0, 64'd0);

    // Byte store into lane 5, then sub-word loads
    access("st_b", 64'h8000_0005, 64'h0000_0000_0000_00F0, SZ_B, 1'b0, 1'b1, ERR_OK,
           64'd0, 64'h0000_FF00_0000_0000, 64'h0000_F000_0000_0000);
    chk("mem_after_st_b", mem[0], 64'h1122_F044_5566_7788);
    access("ld_b_s", 64'h8000_0005, 64'd0, SZ_B, 1'b1, 1'b0, ERR_OK,
           64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0);
    access("ld_b_u", 64'h8000_0005, 64'd0, SZ_B, 1'b0, 1'b0, ERR_OK,
           64'h0000_0000_0000_00F0, 64'd0, 64'd0);
    access("ld_d_nbr", 64'h8000_0000, 64'd0, SZ_D, 1'b1, 1'b0, ERR_OK,
           64'h1122_F044_5566_7788, 64'd0, 64'd0);

    // Alignment
    access("ld_w_mis", 64'h8000_0002, 64'd0, SZ_W, 1'b0, 1'b0, ERR_MISALIGN, 64'd0, 64'd0, 64'd0);
    access("ld_h_6", 64'h8000_0006, 64'd0, SZ_H, 1'b0, 1'b0, ERR_OK,
           64'h0000_0000_0000_1122, 64'd0, 64'd0);
    access("ld_h_4s", 64'h8000_0004, 64'd0, SZ_H, 1'b1, 1'b0, ERR_OK,
           64'hFFFF_FFFF_FFFF_F044, 64'd0, 64'd0);

    // Range boundaries
    access("ld_below", 64'h7FFF_FFF8, 64'd0, SZ_D, 1'b0, 1'b0, ERR_FAULT, 64'd0, 64'd0, 64'd0);
    access("ld_w_last", 64'h87FF_FFFC, 64'd0, SZ_W, 1'b0, 1'b0, ERR_OK,
           64'h0000_0000_CAFE_BABE, 64'd0, 64'd0);
    access("ld_d_mis_end", 64'h87FF_FFFC, 64'd0, SZ_D, 1'b0, 1'b0, ERR_MISALIGN,
           64'd0, 64'd0, 64'd0);
    access("ld_d_past", 64'h8800_0000, 64'd0, SZ_D, 1'b0, 1'b0, ERR_FAULT, 64'd0, 64'd0, 64'd0);
    access("ld_d_wrap", 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, SZ_D, 1'b0, 1'b0, ERR_FAULT,
           64'd0, 64'd0, 64'd0);
    access("st_fault", 64'h7FFF_FFF0, 64'hAAAA, SZ_D, 1'b0, 1'b1, ERR_FAULT, 64'd0, 64'd0, 64'd0);

    // Backpressure: response held, a pending store must not be accepted
    @(negedge clk);
    bus.resp_ready = 1'b0;
    drive(64'h8000_0000, 64'd0, SZ_D, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(64'h8000_0008, 64'h5555_5555_5555_5555, SZ_D, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp:resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp:resp_rdata", bus.resp_rdata,      64'h1122_F044_5566_7788);
      chk("bp:resp_err",   64'(bus.resp_err),   64'(ERR_OK));
      chk("bp:req_ready",  64'(bus.req_ready),  64'd0);
      chk("bp:dmem_en",    64'(dmem_en),        64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    @(posedge clk); #1;
    chk("bp_rel:resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("bp_rel:req_ready",  64'(bus.req_ready),  64'd1);
    access("bp_next", 64'h8000_0008, 64'd0, SZ_D, 1'b0, 1'b0, ERR_OK,
           64'h0123_4567_89AB_CDEF, 64'd0, 64'd0);

    // Reset during the ACCESS cycle of a store
    @(negedge clk);
    drive(64'h8000_0008, 64'hDEAD_BEEF_DEAD_BEEF, SZ_D, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mid:dmem_wen_before", 64'(dmem_wen), 64'd1);
    #2 rst_n = 1'b0;
    #1 reset_vals("mid_rst");
    @(posedge clk); #1;
    chk("mid:mem_unchanged", mem[1], 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    rst_n = 1'b1;
    access("post_rst", 64'h8000_0008, 64'd0, SZ_D, 1'b0, 1'b0, ERR_OK,
           64'h0123_4567_89AB_CDEF, 64'd0, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
